// File: rtl/alu_share_pkg.sv
// Shared constants and types for the two-requester ALU sharing controller.
package alu_share_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  localparam int ID_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester, response, ALU-side and debug signals of alu_share_ctrl.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid and its payload hold until then, and ready may depend combinationally on valid.
interface alu_share_ctrl_if
  import alu_share_pkg::*;
#(
  parameter int W = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [1:0]   req0_op;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [1:0]   req1_op;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [W-1:0] rsp0_res;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [W-1:0] rsp1_res;

  logic [W-1:0] alu_in_a;
  logic [W-1:0] alu_in_b;
  logic [1:0]   alu_opcode;
  logic [W-1:0] alu_res;

  state_t          state_dbg;
  logic [ID_W-1:0] cur_id_dbg;
  logic [ID_W-1:0] last_grant_dbg;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, alu_res,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_res, rsp1_valid, rsp1_res,
    output alu_in_a, alu_in_b, alu_opcode,
    output state_dbg, cur_id_dbg, last_grant_dbg
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, alu_res,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_res, rsp1_valid, rsp1_res,
    input  alu_in_a, alu_in_b, alu_opcode,
    input  state_dbg, cur_id_dbg, last_grant_dbg
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the requester that did not win last time wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered add/sub ALU between two requesters: accept, execute, respond.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int W = 32
) (
  input logic              clk,
  input logic              rst,
  alu_share_ctrl_if.slave  bus
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] cur_id_q;
  logic [ID_W-1:0] last_grant_q;
  logic [W-1:0]    a_q, b_q;
  logic [1:0]      op_q;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       accept;
  logic       rsp_ready_cur;

  rr_arb2 u_arb (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign rsp_ready_cur = (cur_id_q == 1'b1) ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          accept         = 1'b1;
          bus.req0_ready = gnt[0];
          bus.req1_ready = gnt[1];
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        bus.rsp0_valid = (cur_id_q == 1'b0);
        bus.rsp1_valid = (cur_id_q == 1'b1);
        if (rsp_ready_cur) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands stay registered through EXEC and RESP so the ALU output is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cur_id_q     <= gnt_id;
        last_grant_q <= gnt_id;
        a_q          <= gnt_id ? bus.req1_a  : bus.req0_a;
        b_q          <= gnt_id ? bus.req1_b  : bus.req0_b;
        op_q         <= gnt_id ? bus.req1_op : bus.req0_op;
      end
    end
  end

  assign bus.alu_in_a       = a_q;
  assign bus.alu_in_b       = b_q;
  assign bus.alu_opcode     = op_q;
  assign bus.rsp0_res       = bus.alu_res;
  assign bus.rsp1_res       = bus.alu_res;
  assign bus.state_dbg      = state_q;
  assign bus.cur_id_dbg     = cur_id_q;
  assign bus.last_grant_dbg = last_grant_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a registered add/sub ALU beside it.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_share_ctrl_if #(.W(W)) bus ();

  alu_share_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU: registered result, no reset, illegal opcodes give zero.
  always_ff @(posedge clk) begin
    case (bus.alu_opcode)
      OP_ADD:  bus.alu_res <= bus.alu_in_a + bus.alu_in_b;
      OP_SUB:  bus.alu_res <= bus.alu_in_a - bus.alu_in_b;
      default: bus.alu_res <= '0;
    endcase
  end

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 2'b00;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Single uncontended op with response ready high: accept, exec, resp, back in IDLE.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [W-1:0] exp_res);
    set_req(id, a, b, op);
    settle();
    chk($sformatf("op%0d_req0_ready", id), W'(bus.req0_ready), W'(id == 0));
    chk($sformatf("op%0d_req1_ready", id), W'(bus.req1_ready), W'(id == 1));
    next_cycle();
    idle_inputs();
    settle();
    chk($sformatf("op%0d_exec_state", id), W'(bus.state_dbg), W'(ST_EXEC));
    chk($sformatf("op%0d_alu_a", id), bus.alu_in_a, a);
    chk($sformatf("op%0d_alu_op", id), W'(bus.alu_opcode), W'(op));
    chk($sformatf("op%0d_exec_rsp", id), W'({bus.rsp1_valid, bus.rsp0_valid}), W'(0));
    next_cycle();
    chk($sformatf("op%0d_rsp_valid", id), W'({bus.rsp1_valid, bus.rsp0_valid}),
        W'(id == 0 ? 2'b01 : 2'b10));
    chk($sformatf("op%0d_rsp_res", id), (id == 0) ? bus.rsp0_res : bus.rsp1_res, exp_res);
    next_cycle();
    chk($sformatf("op%0d_back_idle", id), W'(bus.state_dbg), W'(ST_IDLE));
    chk($sformatf("op%0d_rsp_clear", id), W'({bus.rsp1_valid, bus.rsp0_valid}), W'(0));
  endtask

  // ---- directed sequence ----
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();

    // Reset state
    do_reset();
    settle();
    chk("rst_state", W'(bus.state_dbg), W'(ST_IDLE));
    chk("rst_cur_id", W'(bus.cur_id_dbg), W'(0));
    chk("rst_last_grant", W'(bus.last_grant_dbg), W'(1));
    chk("rst_alu_a", bus.alu_in_a, '0);
    chk("rst_alu_b", bus.alu_in_b, '0);
    chk("rst_alu_op", W'(bus.alu_opcode), W'(0));
    chk("rst_ready", W'({bus.req1_ready, bus.req0_ready}), W'(0));
    chk("rst_rsp_valid", W'({bus.rsp1_valid, bus.rsp0_valid}), W'(0));

    // Single add, then subtract with wrap
    run_op(0, 32'd5, 32'd3, 2'b00, 32'd8);
    run_op(1, 32'd0, 32'd1, 2'b01, 32'hFFFF_FFFF);

    // Simultaneous held requests after reset: 0, 1, 0
    do_reset();
    set_req(0, 32'd1, 32'd1, 2'b00);
    set_req(1, 32'd2, 32'd2, 2'b00);
    for (int k = 0; k < 3; k++) begin
      int win;
      win = (k == 1) ? 1 : 0;
      settle();
      chk($sformatf("tie%0d_ready", k), W'({bus.req1_ready, bus.req0_ready}),
          W'(win == 0 ? 2'b01 : 2'b10));
      next_cycle();
      chk($sformatf("tie%0d_exec_ready", k), W'({bus.req1_ready, bus.req0_ready}), W'(0));
      next_cycle();
      chk($sformatf("tie%0d_rsp_valid", k), W'({bus.rsp1_valid, bus.rsp0_valid}),
          W'(win == 0 ? 2'b01 : 2'b10));
      chk($sformatf("tie%0d_res", k), (win == 0) ? bus.rsp0_res : bus.rsp1_res,
          (win == 0) ? 32'd2 : 32'd4);
      chk($sformatf("tie%0d_resp_ready", k), W'({bus.req1_ready, bus.req0_ready}), W'(0));
      next_cycle();
    end
    idle_inputs();
    settle();

    // Back-pressure on requester 0 while requester 1 waits
    set_req(0, 32'd10, 32'd20, 2'b00);
    settle();
    chk("bp_accept", W'(bus.req0_ready), W'(1));
    next_cycle();
    idle_inputs();
    bus.rsp0_ready = 1'b0;
    set_req(1, 32'd100, 32'd1, 2'b01);
    settle();
    chk("bp_exec_req1_ready", W'(bus.req1_ready), W'(0));
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_valid", k), W'(bus.rsp0_valid), W'(1));
      chk($sformatf("bp%0d_res", k), bus.rsp0_res, 32'd30);
      chk($sformatf("bp%0d_req1_ready", k), W'(bus.req1_ready), W'(0));
      next_cycle();
    end
    bus.rsp0_ready = 1'b1;
    settle();
    chk("bp_release_valid", W'(bus.rsp0_valid), W'(1));
    chk("bp_release_res", bus.rsp0_res, 32'd30);
    chk("bp_release_req1_ready", W'(bus.req1_ready), W'(0));
    next_cycle();
    chk("bp_reenter_idle", W'(bus.state_dbg), W'(ST_IDLE));
    chk("bp_req1_granted", W'(bus.req1_ready), W'(1));
    next_cycle();
    idle_inputs();
    next_cycle();
    chk("bp_req1_res", bus.rsp1_res, 32'd99);
    chk("bp_req1_valid", W'({bus.rsp1_valid, bus.rsp0_valid}), W'(2'b10));
    next_cycle();

    // Illegal opcode completes with zero
    run_op(0, 32'd7, 32'd7, 2'b11, 32'd0);

    // Reset during EXEC drops the operation
    set_req(1, 32'd4, 32'd5, 2'b01);
    next_cycle();
    idle_inputs();
    settle();
    chk("mid_in_exec", W'(bus.state_dbg), W'(ST_EXEC));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("mid_state", W'(bus.state_dbg), W'(ST_IDLE));
    chk("mid_alu_op", W'(bus.alu_opcode), W'(0));
    chk("mid_last_grant", W'(bus.last_grant_dbg), W'(1));
    chk("mid_cur_id", W'(bus.cur_id_dbg), W'(0));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid%0d_no_rsp", k), W'({bus.rsp1_valid, bus.rsp0_valid}), W'(0));
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
